// File: rtl/mcbsp_rx_deser_if.sv
// mcbsp_rx_deser_if: chunk stream from the McBSP receive deserialiser to its consumer.
`timescale 1ns/1ps
interface mcbsp_rx_deser_if #(
  parameter int OUT_W  = 8,
  parameter int CHAN_W = 1
);
  logic              dataValid;
  logic              dataReady;
  logic [OUT_W-1:0]  data;
  logic [CHAN_W-1:0] dataChan;
  logic              dataLast;
  modport master (output dataValid, data, dataChan, dataLast, input dataReady);
  modport slave  (input dataValid, data, dataChan, dataLast, output dataReady);
endinterface

// File: rtl/mcbsp_rx_deser.sv
// mcbsp_rx_deser: McBSP receive deserialiser slicing frames into tagged chunks behind a small FIFO.
`timescale 1ns/1ps
module mcbsp_rx_deser #(
  parameter int WORD_W          = 16,
  parameter int OUT_W           = 8,
  parameter int WORDS_PER_FRAME = 1,
  parameter int DATA_DELAY      = 1,
  parameter int MSB_FIRST       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic interfaceClk,
  input  logic nRst,
  input  logic McBSPFSR,
  input  logic McBSPDR,
  input  logic clrStatus,
  mcbsp_rx_deser_if.master rx,
  output logic frameErr,
  output logic overflow
);
  localparam int CHAN_W = WORDS_PER_FRAME > 1 ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int CPW    = WORD_W / OUT_W;
  localparam int BW     = OUT_W > 1 ? $clog2(OUT_W) : 1;
  localparam int CW     = CPW > 1 ? $clog2(CPW) : 1;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int EW     = OUT_W + CHAN_W + 1;

  typedef enum logic [1:0] {IDLE, DELAY, RECV} stateT;

  stateT             state;
  logic              fsrQ;
  logic [1:0]        dcnt;
  logic [OUT_W-1:0]  sh, shNext;
  logic [BW-1:0]     bcnt, bcntE;
  logic [CW-1:0]     ccnt, ccntE;
  logic [CHAN_W-1:0] wcnt, wcntE;
  logic              fs, sample, chunkDone, wordDone, lastChunk;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wrPtr, rdPtr;
  logic [PW:0]       count;
  logic              notEmpty, full, pop, push, drop;

  // A frame start anywhere restarts counting from zero, so the effective counters mask on fs.
  always_comb begin
    fs        = McBSPFSR & ~fsrQ;
    sample    = fs ? (DATA_DELAY == 0) : (state == DELAY) ? (dcnt == 2'd1) : (state == RECV);
    bcntE     = fs ? '0 : bcnt;
    ccntE     = fs ? '0 : ccnt;
    wcntE     = fs ? '0 : wcnt;
    shNext    = MSB_FIRST != 0 ? {sh[OUT_W-2:0], McBSPDR} : {McBSPDR, sh[OUT_W-1:1]};
    chunkDone = sample & (bcntE == BW'(OUT_W - 1));
    wordDone  = chunkDone & (ccntE == CW'(CPW - 1));
    lastChunk = wordDone & (wcntE == CHAN_W'(WORDS_PER_FRAME - 1));
    notEmpty  = count != '0;
    full      = count == (PW+1)'(FIFO_DEPTH);
    pop       = notEmpty & rx.dataReady;
    push      = chunkDone & (~full | pop);
    drop      = chunkDone & full & ~pop;
  end

  always_ff @(negedge interfaceClk or negedge nRst)
    if (!nRst) begin
      state    <= IDLE;
      fsrQ     <= 1'b0;
      dcnt     <= '0;
      sh       <= '0;
      bcnt     <= '0;
      ccnt     <= '0;
      wcnt     <= '0;
      frameErr <= 1'b0;
    end else begin
      fsrQ     <= McBSPFSR;
      frameErr <= fs & (state != IDLE);
      dcnt     <= fs ? 2'(DATA_DELAY) : (state == DELAY) ? dcnt - 2'd1 : dcnt;
      sh       <= sample ? shNext : sh;
      bcnt     <= !sample ? bcntE : chunkDone ? '0 : bcntE + 1'b1;
      ccnt     <= !chunkDone ? ccntE : wordDone ? '0 : ccntE + 1'b1;
      wcnt     <= !wordDone ? wcntE : lastChunk ? '0 : wcntE + 1'b1;
      state    <= lastChunk ? IDLE
                : fs ? (DATA_DELAY == 0 ? RECV : DELAY)
                : (state == DELAY && dcnt == 2'd1) ? RECV : state;
    end

  always_ff @(negedge interfaceClk or negedge nRst)
    if (!nRst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wrPtr    <= wrPtr + PW'(push);
      rdPtr    <= rdPtr + PW'(pop);
      count    <= count + (PW+1)'(push) - (PW+1)'(pop);
      overflow <= drop | (overflow & ~clrStatus);
    end

  always_ff @(negedge interfaceClk)
    if (push) mem[wrPtr] <= {lastChunk, wcntE, shNext};

  assign rx.dataValid = notEmpty;
  assign {rx.dataLast, rx.dataChan, rx.data} = notEmpty ? mem[rdPtr] : '0;
endmodule

// File: doc/mcbsp_rx_deser.md
# mcbsp_rx_deser

Parametrised McBSP receive deserialiser: captures a serial McBSP frame of WORDS_PER_FRAME words of WORD_W bits, slices it into OUT_W-bit chunks, and buffers them in a small FIFO with a valid/ready handshake. It sits between the DSP McBSP transmit pins and the logging packetiser. It adds the following over the fixed 16-to-8 receiver:
- programmable data delay;
- multi-word frames with channel tagging;
- bit order selection;
- backpressure;
- frame-error and overflow reporting.

## Interface
- WORD_W, 16, bits per McBSP word; must be an integer multiple of OUT_W.
- OUT_W, 8, output chunk width.
- WORDS_PER_FRAME, 1, words per frame, 1..16.
- DATA_DELAY, 1, falling edges from the FSR-detect edge to the first data-bit sample, 0..2.
- MSB_FIRST, 1, 1: first received bit of a chunk is its MSB; 0: it is bit 0.
- FIFO_DEPTH, 4, chunk FIFO entries, power of 2, ≥2.
- interfaceClk  in  1  McBSP CLKR, 10 MHz. All flops update on its falling edge.
- nRst  in  1  Reset nRst, asynchronous, active-low.
- McBSPFSR  in  1  frame sync, active high.
- McBSPDR  in  1  serial data.
- clrStatus  in  1  clears sticky overflow.
- dataValid  out  1  FIFO non-empty.
- dataReady  in  1  consumer accepts the head entry on an edge where dataValid&dataReady.
- data  out  OUT_W  head chunk.
- dataChan  out  max(1,clog2(WORDS_PER_FRAME))  word index within frame of head chunk.
- dataLast  out  1  head chunk is the final chunk of its frame.
- frameErr  out  1  one-cycle pulse, frame aborted.
- overflow  out  1  sticky, a chunk was dropped.

## Operation
- fsr_q registers McBSPFSR. A frame start (FS) is McBSPFSR=1 and fsr_q=0 at a falling edge.
- States:
  - IDLE: on FS, go to DELAY with dcnt=DATA_DELAY. If DATA_DELAY=0, go straight to RECV and sample the bit on that same edge.
  - DELAY: decrement dcnt each edge. On reaching 0, enter RECV; the sample taken on the entering edge is bit 0.
  - RECV: one McBSPDR sample per edge, into shift register plus bit counter (0..OUT_W-1), chunk counter (0..WORD_W/OUT_W-1) and word counter (0..WORDS_PER_FRAME-1).
- Chunk completion: when the OUT_W-th bit is sampled, the chunk {bits, word index, last} is pushed on that same edge.
  - last=1 for the final chunk of the final word.
  - After the last push, return to IDLE.
- Bit order:
  - MSB_FIRST=1: shift left, new bit in LSB.
  - MSB_FIRST=0: shift right, new bit in MSB.
  - Chunks are emitted in arrival order.
- FS while in DELAY or RECV:
  - the partial chunk is discarded;
  - already-pushed chunks stay in the FIFO;
  - frameErr pulses for that edge;
  - the FS restarts the frame exactly as from IDLE (counters cleared, word index 0).
- McBSPFSR held high does not retrigger. McBSPFSR level in RECV is otherwise ignored.
- FIFO push while full:
  - if a pop occurs on the same edge, the push is accepted and count is unchanged;
  - otherwise the chunk is dropped, overflow sets, and reception continues (counters still advance, so a later last flag is still generated).
- Pop on empty: no effect.
- clrStatus clears overflow. If a drop occurs on the same edge, the drop wins and overflow stays 1.

## Timing
- Reset (async assert, release synchronised to the falling edge):
  - state IDLE, FIFO empty;
  - dataValid=0, data=0, dataChan=0, dataLast=0, frameErr=0, overflow=0;
  - fsr_q=0, so McBSPFSR already high at release counts as FS.
- Reset mid-frame discards everything. No frameErr is generated.
- Latency: the last bit of a chunk is sampled at edge N. Its entry is visible (dataValid=1 if FIFO was empty) immediately after edge N.
- Head data/dataChan/dataLast are combinational from FIFO storage and stable while dataValid=1 and no pop.
- A pop at edge M presents the next entry after edge M. dataValid falls after M if count becomes 0.
- Back-to-back frames: FS may coincide with the edge after the last bit. No dead cycle is required.
- Frame length in edges from FS: DATA_DELAY + WORD_W*WORDS_PER_FRAME; with DATA_DELAY=0 the FS edge counts as the first sample.

## Test plan
- Defaults, FS then bits 0xA55A MSB-first, dataReady=1 -> 0xA5 with dataLast=0 after bit 8, then 0x5A with dataLast=1 after bit 16, frameErr=0.
- WORDS_PER_FRAME=2, DATA_DELAY=2, MSB_FIRST=0, send 0x1234 then 0xABCD LSB-first -> chunks 0x34/0x12 with dataChan=0, then 0xCD/0xAB with dataChan=1, last on 0xAB; first sample exactly 2 edges after FS.
- dataReady=0, FIFO_DEPTH=4, send 3 frames (6 chunks) -> first 4 chunks retained in order, overflow=1 after the 5th chunk. Pulse clrStatus -> overflow=0.
- Second FS after 11 bits of a frame -> frameErr=1 for one edge, first chunk kept, partial chunk discarded, new frame decoded correctly.
- FIFO full with dataReady=1 on the same edge a chunk completes -> no drop, count stays 4, overflow=0.
- nRst asserted mid-frame, then released with FSR high -> all outputs 0 during reset, and the new frame decodes from the FS seen at release.
